cpu: RTL and testbench
======================

Name: cpu

Overview:
- Top-level program-3 engine. On a Start handshake it reads a 16-bit unsigned operand from its internal data memory and computes the integer square root, floor(sqrt(x)).
- It writes the 8-bit root back to data memory and raises Ack.
- The data memory is an internal instance named DM1 whose storage array is named Core. Benches load operands and read results through the hierarchical path DM1.Core.

Parameters:
- DM_DEPTH, 256, number of 8-bit words in DM1.Core, addresses 0..DM_DEPTH-1.
- OP_ADDR, 16, address of operand MSB; the LSB is at OP_ADDR+1 (17).
- RES_ADDR, 18, address where the 8-bit root is written.

Ports:
- Clk  input  1  single system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset of all control state.
- Start  input  1  launch request; held high during setup, the run begins when Start is low.
- Ack  output  1  program-complete flag.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset effects:
  - FSM goes to IDLE and Ack=0.
  - Working registers (operand, root, remainder, bit counter) are cleared.
  - DM1.Core contents are NOT reset, so a bench may preload memory while Reset is still high or in the same cycle it falls.
- DM1 storage:
  - Array Core[0:DM_DEPTH-1] of 8-bit regs.
  - Combinational read; synchronous write on rising Clk.
  - Must remain writable by hierarchical assignment from a bench.
- FSM states: IDLE, LOAD_HI, LOAD_LO, CALC, WRITE, DONE.
- IDLE: Ack=0. On a rising edge with Start=0, go to LOAD_HI. While Start=1, stay in IDLE.
- LOAD_HI: latch op[15:8] from Core[OP_ADDR]. Go to LOAD_LO.
- LOAD_LO:
  - Latch op[7:0] from Core[OP_ADDR+1].
  - Init root=0, remainder=0, counter=7.
  - Go to CALC.
- CALC: one digit per cycle, 8 cycles, counter 7 down to 0. Restoring bit-pair algorithm:
  - Shift the remainder left 2 and bring in the next two operand bits, MSB pair first.
  - trial = {root,2'b01}.
  - If remainder >= trial, then remainder -= trial and root = {root,1}; else root = {root,0}.
  - The remainder is 10 bits wide and the root is 8 bits wide.
  - When counter reaches 0, go to WRITE.
- WRITE: Core[RES_ADDR] <= root. Go to DONE.
- DONE: Ack=1, registered.
  - Stay in DONE while Start=0.
  - On Start=1, return to IDLE and drop Ack.
  - A new run then begins when Start falls again.
- Latency:
  - Edge 1 is the first rising edge at which Start=0 is sampled in IDLE.
  - Ack rises at edge 12.
  - Core[RES_ADDR] is valid no later than the edge on which Ack rises.
- Result: root = floor(sqrt(op)), range 0..255.
  - op=0 gives 0.
  - op=65535 gives 0xFF; no overflow is possible.
- Memory side effects: only Core[RES_ADDR] is written. Operand bytes and all other words are unchanged.
- Start rising mid-run (LOAD_*, CALC, WRITE) is ignored; the run completes and Ack is raised.
- Reset mid-run aborts immediately: IDLE, Ack=0, and the result is not written.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- When defined:
  - An extra ROUND state sits between CALC and WRITE, so Ack rises at edge 13.
  - If root != 0xFF and op > root*root + root, root is incremented by 1. This is round to nearest, saturating at 0xFF.
- When undefined: the result is floor as above, with no ROUND state.

Test Plan:
- Reset=1,Start=1; preload Core[16]=0x00, Core[17]=0xBE (190); drop Reset; drop Start 2 cycles later.
  - Required: Ack=1 at edge 12, Core[18]=0x0D (13).
  - With SQRT_ROUND_EN: Core[18]=0x0E.
- op=0x0000 -> Core[18]=0x00, Ack asserted.
- op=0xFFFF -> Core[18]=0xFF, also 0xFF with SQRT_ROUND_EN (saturation).
- op=0x0100 (256) -> Core[18]=0x10.
- op=0x00FF (255) -> Core[18]=0x0F.
  - With SQRT_ROUND_EN: 0x10.
  - Core[16], Core[17] unchanged.
- Assert Reset during CALC -> Ack=0 immediately; Core[18] keeps its prior value.
  - Then Start high->low -> fresh run gives the correct result.
  - Start pulse after DONE returns to IDLE, drops Ack, and reruns.

Source files
------------

// File: rtl/cpu.sv
// cpu: program-3 engine. On a Start handshake it reads a 16-bit operand from
// its internal data memory (DM1.Core[OP_ADDR] = MSB, [OP_ADDR+1] = LSB),
// computes floor(sqrt(op)) one root bit per cycle with a restoring bit-pair
// recurrence, writes the 8-bit root to DM1.Core[RES_ADDR] and raises Ack.
//
// Ports:
//   Clk    rising-edge system clock
//   Reset  asynchronous active-high reset of all control/working state
//   Start  launch request: a run begins on the first edge that sees Start=0
//          in IDLE; Start=1 in DONE drops Ack and returns to IDLE
//   Ack    registered program-complete flag
//
// Optional build macro: SQRT_ROUND_EN -- adds a ROUND state between CALC and
// WRITE that rounds the root to nearest, saturating at 0xFF.

// Data memory: combinational read, synchronous write, no reset so a bench
// can preload Core hierarchically at any time.
module cpu_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] Core [0:DEPTH-1];

  assign rdata = Core[raddr];

  always_ff @(posedge clk)
    if (we) Core[waddr] <= wdata;
endmodule

module cpu #(
  parameter int DM_DEPTH = 256,
  parameter int OP_ADDR  = 16,
  parameter int RES_ADDR = 18
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  localparam int AW = $clog2(DM_DEPTH);
  localparam logic [AW-1:0] A_HI  = AW'(OP_ADDR);
  localparam logic [AW-1:0] A_LO  = AW'(OP_ADDR + 1);
  localparam logic [AW-1:0] A_RES = AW'(RES_ADDR);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, CALC, ROUND, WRITE, DONE
  } state_t;

  state_t state, state_n;

  logic [15:0] op;
  logic [7:0]  root;
  logic [9:0]  rem;
  logic [2:0]  cnt;

  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic          we;

  cpu_dm #(.DEPTH(DM_DEPTH), .AW(AW)) DM1 (
    .clk   (Clk),
    .we    (we),
    .waddr (A_RES),
    .wdata (root),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign raddr = (state == LOAD_LO) ? A_LO : A_HI;
  assign we    = (state == WRITE);

  // One recurrence step: the remainder stays below 2*root+1, so its low
  // 8 bits carry everything before the shift.
  logic [3:0] pidx;
  logic [9:0] rem_sh, trial;
  assign pidx   = {cnt, 1'b1};
  assign rem_sh = {rem[7:0], op[pidx -: 2]};
  assign trial  = {root, 2'b01};

`ifdef SQRT_ROUND_EN
  // Round-to-nearest threshold: op > r^2 + r  <=>  op >= (r + 0.5)^2.
  logic [16:0] rnd_thr;
  assign rnd_thr = 17'(root) * 17'(root) + 17'(root);
`endif

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!Start) state_n = LOAD_HI;
      LOAD_HI: state_n = LOAD_LO;
      LOAD_LO: state_n = CALC;
`ifdef SQRT_ROUND_EN
      CALC:    if (cnt == 3'd0) state_n = ROUND;
      ROUND:   state_n = WRITE;
`else
      CALC:    if (cnt == 3'd0) state_n = WRITE;
`endif
      WRITE:   state_n = DONE;
      DONE:    if (Start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      op   <= '0;
      root <= '0;
      rem  <= '0;
      cnt  <= '0;
      Ack  <= 1'b0;
    end else begin
      Ack <= (state_n == DONE);
      case (state)
        LOAD_HI: op[15:8] <= rdata;
        LOAD_LO: begin
          op[7:0] <= rdata;
          root    <= '0;
          rem     <= '0;
          cnt     <= 3'd7;
        end
        CALC: begin
          cnt <= cnt - 3'd1;
          if (rem_sh >= trial) begin
            rem  <= rem_sh - trial;
            root <= {root[6:0], 1'b1};
          end else begin
            rem  <= rem_sh;
            root <= {root[6:0], 1'b0};
          end
        end
`ifdef SQRT_ROUND_EN
        ROUND:
          if (root != 8'hFF && {1'b0, op} > rnd_thr) root <= root + 8'd1;
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int errs = 0;
  int checks = 0;

`ifdef SQRT_ROUND_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  cpu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: search for the integer root directly, then optional rounding.
  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
`ifdef SQRT_ROUND_EN
    if (r < 255 && (x - r * r) > r) r++;
`endif
    return r;
  endfunction

  // Expects DUT in IDLE with Start=1. Runs one operand and checks latency,
  // result, memory side effects and the Start-driven return to IDLE.
  task automatic run_op(input logic [15:0] op, input string tag);
    int n;
    int exp_r;
    logic [7:0] other;
    exp_r = ref_root(int'(op));
    other = 8'($urandom);
    dut.DM1.Core[16] = op[15:8];
    dut.DM1.Core[17] = op[7:0];
    dut.DM1.Core[18] = ~8'(exp_r);
    dut.DM1.Core[40] = other;
    @(negedge Clk) Start = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge Clk); #1;
      n++;
      if (Ack) break;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_res"}, 32'(dut.DM1.Core[18]), 32'(exp_r));
    chk({tag, "_hi"}, 32'(dut.DM1.Core[16]), 32'(op[15:8]));
    chk({tag, "_lo"}, 32'(dut.DM1.Core[17]), 32'(op[7:0]));
    chk({tag, "_oth"}, 32'(dut.DM1.Core[40]), 32'(other));
    repeat (2) @(posedge Clk);
    #1 chk({tag, "_hold"}, 32'(Ack), 1);
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_drop"}, 32'(Ack), 0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b1;
    dut.DM1.Core[16] = 8'h00;
    dut.DM1.Core[17] = 8'hBE;
    #1 chk("rst_ack", 32'(Ack), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    run_op(16'h00BE, "op190");
    run_op(16'h0000, "op0");
    run_op(16'hFFFF, "opffff");
    run_op(16'h0100, "op256");
    run_op(16'h00FF, "op255");
    run_op(16'h0001, "op1");
    run_op(16'hFE01, "op65025");
    for (int i = 0; i < 16; i++) run_op(16'($urandom), "rnd");

    // Reset in CALC: aborts, no write.
    dut.DM1.Core[16] = 8'h12;
    dut.DM1.Core[17] = 8'h34;
    dut.DM1.Core[18] = 8'hA5;
    @(negedge Clk) Start = 1'b0;
    repeat (6) @(posedge Clk);
    #2 Reset = 1'b1;
    #1 chk("midrst_ack", 32'(Ack), 0);
    repeat (12) @(posedge Clk);
    #1 chk("midrst_keep", 32'(dut.DM1.Core[18]), 32'hA5);
    chk("midrst_ack2", 32'(Ack), 0);
    @(negedge Clk) begin Start = 1'b1; Reset = 1'b0; end
    @(negedge Clk);
    run_op(16'h1234, "post_rst");

    // Async reset while in DONE drops Ack before the next edge.
    @(negedge Clk) Start = 1'b0;
    repeat (LAT + 1) @(posedge Clk);
    #1 chk("done_ack", 32'(Ack), 1);
    #1 Reset = 1'b1;
    #1 chk("done_rst_ack", 32'(Ack), 0);
    @(negedge Clk) begin Start = 1'b1; Reset = 1'b0; end
    @(negedge Clk);
    run_op(16'h2710, "op10000");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
